uart_time_reporter: RTL and testbench
=====================================

Name: uart_time_reporter

Overview:
- Transmit-side counterpart to the UART command path: formats the current time digits into an ASCII frame and streams it byte-by-byte into the UART transmitter.
- Sits between time_sel (digit_h, digit_l, dot) and the uart tx_data/start/o_tx_done interface, replacing the raw rx echo.
- Frame is 7 bytes: H1 H0 SEP L1 L0 CR LF, for example "12:34\r\n".

Parameters:
- AUTO_SEND, 1, 1 = also start a frame whenever the latched digit_l value changes; 0 = send only on send_req.
- SEP_DOT, 8'h2E, separator byte used when dot=1.
- SEP_NODOT, 8'h3A, separator byte used when dot=0.

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-high reset.
- send_req  in  1  single-cycle request to transmit one frame.
- digit_h  in  7  upper time field, binary 0..99.
- digit_l  in  7  lower time field, binary 0..99.
- dot  in  1  separator select.
- tx_done  in  1  single-cycle pulse from the uart when a byte has finished.
- tx_start  out  1  single-cycle pulse; tx_data is valid in the same cycle.
- tx_data  out  8  byte to transmit.
- busy  out  1  high from frame latch until the last tx_done.
- sat  out  1  sticky per frame: a field exceeding 99 was clamped.

Behaviour:
- Reset state:
  - tx_start=0, tx_data=8'h00, busy=0, sat=0.
  - State is IDLE, byte index is 0, pending is 0.
  - The last_l register is loaded with 0.
- State machine: IDLE, LATCH, SEND, WAIT.
- IDLE: on a trigger (send_req, or AUTO_SEND and digit_l != last_l, or pending=1), go to LATCH. pending clears in that cycle.
- LATCH (one cycle):
  - Capture digit_h, digit_l and dot. Update last_l to digit_l.
  - Clamp each field to 99 if it is greater than 99. Set sat=1 if either field was clamped, otherwise sat=0.
  - Convert each field to tens/units by iterative subtraction of 10 or a comparison ladder. No divider is used.
  - ASCII digit = 8'h30 + nibble.
  - busy=1. Byte index = 0. Go to SEND.
- SEND (one cycle):
  - tx_start=1 and tx_data = frame[index].
  - Byte order is H tens, H units, SEP, L tens, L units, 8'h0D, 8'h0A.
  - Go to WAIT.
- WAIT:
  - Hold tx_data stable and keep tx_start=0.
  - On tx_done: if index=6, set busy=0 and go to IDLE. Otherwise increment index and go to SEND.
- Latency:
  - First tx_start occurs 2 cycles after the trigger cycle.
  - Each following tx_start occurs 1 cycle after the tx_done of the previous byte.
- Requests while busy: any trigger sets pending=1. Multiple triggers coalesce into one frame. That frame re-latches the inputs as they are when it starts.
- Simultaneous tx_done and send_req in the last WAIT cycle: the frame completes and pending is set. The next frame starts from IDLE on the following cycle.
- tx_done while in IDLE, LATCH or SEND is ignored.
- Input changes during a frame do not alter the bytes in flight.
- Asynchronous reset mid-frame:
  - Abort immediately and return all registers to their reset values.
  - No further tx_start is issued. A partial frame on the line is acceptable.

Decomposition:
- Shared package (uart_pkg): ASCII constants (ZERO 8'h30, CR 8'h0D, LF 8'h0A, COLON 8'h3A, DOT 8'h2E), FRAME_LEN=7, and the state encoding.
- Sub-module bin2bcd_99 (combinational): 7-bit in, clamped tens/units nibbles out, plus a clamp flag. Two instances, one per field.

Test Plan:
- digit_h=12, digit_l=34, dot=0, pulse send_req; uart model returns tx_done 20 cycles after each start:
  - tx_data sequence is 31 32 3A 33 34 0D 0A.
  - Exactly 7 tx_start pulses.
  - busy falls the cycle after the 7th tx_done.
- dot=1, digit_h=0, digit_l=5 -> bytes 30 30 2E 30 35 0D 0A.
- digit_h=120, digit_l=99 -> frame "99:99\r\n" and sat=1. A following frame with 10/10 -> sat=0.
- Three send_req pulses during byte 3 of a frame:
  - Exactly one additional frame follows.
  - It uses the inputs as they are at its LATCH.
- AUTO_SEND=1: digit_l steps 0->1->2, spaced wider than one frame time -> 2 frames. A spacing of 1 cycle -> 1 frame plus 1 pending frame.
- Assert reset after the 4th tx_start:
  - All outputs are 0 in the same cycle.
  - No tx_start until a new send_req.
  - The next frame is complete and correct.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared constants and state encoding for the UART time reporter slice.
package uart_pkg;

  localparam logic [7:0] ASCII_ZERO  = 8'h30;
  localparam logic [7:0] ASCII_CR    = 8'h0D;
  localparam logic [7:0] ASCII_LF    = 8'h0A;
  localparam logic [7:0] ASCII_COLON = 8'h3A;
  localparam logic [7:0] ASCII_DOT   = 8'h2E;

  localparam int unsigned FRAME_LEN = 7;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_LATCH,
    ST_SEND,
    ST_WAIT
  } state_t;

  function automatic logic [7:0] ascii_digit(input logic [3:0] nibble);
    return ASCII_ZERO + {4'h0, nibble};
  endfunction

endpackage

// File: rtl/uart_time_reporter_if.sv
// Byte-stream handshake between the time reporter and the UART transmitter.
interface uart_time_reporter_if;
  logic       tx_start;
  logic [7:0] tx_data;
  logic       tx_done;

  modport master (output tx_start, output tx_data, input tx_done);
  modport slave  (input tx_start, input tx_data, output tx_done);
endinterface

// File: rtl/uart_time_reporter_bin2bcd_99.sv
// Combinational 0..99 binary to two BCD digits; inputs above 99 clamp to 99.
module bin2bcd_99 (
  input  logic [6:0] bin,
  output logic [3:0] tens,
  output logic [3:0] units,
  output logic       clamped
);

  logic [6:0] rem;

  always_comb begin
    clamped = (bin > 7'd99);
    rem     = clamped ? 7'd99 : bin;
    tens    = '0;
    // Nine conditional subtractions cover the whole 0..99 range without a divider.
    for (int unsigned i = 0; i < 9; i++) begin
      if (rem >= 7'd10) begin
        rem  = rem - 7'd10;
        tens = tens + 4'd1;
      end
    end
    units = rem[3:0];
  end

endmodule

// File: rtl/uart_time_reporter.sv
// Formats digit_h/digit_l as "HH:LL\r\n" and streams it byte-by-byte to the UART.
module uart_time_reporter
  import uart_pkg::*;
#(
  parameter bit         AUTO_SEND = 1'b1,
  parameter logic [7:0] SEP_DOT   = ASCII_DOT,
  parameter logic [7:0] SEP_NODOT = ASCII_COLON
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        send_req,
  input  logic [6:0]                  digit_h,
  input  logic [6:0]                  digit_l,
  input  logic                        dot,
  uart_time_reporter_if.master        tx,
  output logic                        busy,
  output logic                        sat
);

  state_t     state, state_nxt;
  logic [2:0] idx;
  logic       pending;
  logic [6:0] last_l;
  logic [3:0] h_tens_q, h_units_q, l_tens_q, l_units_q;
  logic [7:0] sep_q;

  logic [3:0] h_tens, h_units, l_tens, l_units;
  logic       h_clamp, l_clamp;
  logic       new_req, trig, last_byte;
  logic [7:0] frame_byte;

  bin2bcd_99 u_conv_h (.bin(digit_h), .tens(h_tens), .units(h_units), .clamped(h_clamp));
  bin2bcd_99 u_conv_l (.bin(digit_l), .tens(l_tens), .units(l_units), .clamped(l_clamp));

  assign new_req   = send_req | (AUTO_SEND && (digit_l != last_l));
  assign trig      = new_req | pending;
  assign last_byte = (idx == 3'(FRAME_LEN - 1));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= ST_IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:  if (trig) state_nxt = ST_LATCH;
      ST_LATCH: state_nxt = ST_SEND;
      ST_SEND:  state_nxt = ST_WAIT;
      ST_WAIT:  if (tx.tx_done) state_nxt = last_byte ? ST_IDLE : ST_SEND;
      default:  state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    frame_byte = ASCII_LF;
    case (idx)
      3'd0:    frame_byte = ascii_digit(h_tens_q);
      3'd1:    frame_byte = ascii_digit(h_units_q);
      3'd2:    frame_byte = sep_q;
      3'd3:    frame_byte = ascii_digit(l_tens_q);
      3'd4:    frame_byte = ascii_digit(l_units_q);
      3'd5:    frame_byte = ASCII_CR;
      default: frame_byte = ASCII_LF;
    endcase
  end

  always_comb begin
    tx.tx_start = (state == ST_SEND);
    tx.tx_data  = '0;
    if (state == ST_SEND || state == ST_WAIT) tx.tx_data = frame_byte;
    busy = (state != ST_IDLE);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      idx       <= '0;
      pending   <= 1'b0;
      last_l    <= '0;
      h_tens_q  <= '0;
      h_units_q <= '0;
      l_tens_q  <= '0;
      l_units_q <= '0;
      sep_q     <= '0;
      sat       <= 1'b0;
    end else begin
      pending <= (state == ST_IDLE) ? 1'b0 : (pending | new_req);
      case (state)
        // last_l also follows the triggering value, so a further change seen
        // during LATCH counts as a new request rather than the original one.
        ST_IDLE: if (trig) last_l <= digit_l;
        ST_LATCH: begin
          last_l    <= digit_l;
          h_tens_q  <= h_tens;
          h_units_q <= h_units;
          l_tens_q  <= l_tens;
          l_units_q <= l_units;
          sep_q     <= dot ? SEP_DOT : SEP_NODOT;
          sat       <= h_clamp | l_clamp;
          idx       <= '0;
        end
        ST_WAIT: if (tx.tx_done) idx <= last_byte ? '0 : idx + 3'd1;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_time_reporter.sv
// Scoreboard bench: expected frames queued at stimulus, compared to captured tx bytes.
module tb_uart_time_reporter;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       send_req = 1'b0;
  logic [6:0] digit_h = '0;
  logic [6:0] digit_l = '0;
  logic       dot = 1'b0;
  logic       busy, sat;
  logic [6:0] a_digit_l = '0;
  logic       a_busy, a_sat;
  logic       inj_done = 1'b0;

  uart_time_reporter_if mtx ();
  uart_time_reporter_if atx ();

  uart_time_reporter #(.AUTO_SEND(1'b0), .SEP_DOT(8'h2E), .SEP_NODOT(8'h3A)) dut (
    .clk(clk), .reset(reset), .send_req(send_req), .digit_h(digit_h), .digit_l(digit_l),
    .dot(dot), .tx(mtx), .busy(busy), .sat(sat));

  uart_time_reporter #(.AUTO_SEND(1'b1)) dut_auto (
    .clk(clk), .reset(reset), .send_req(1'b0), .digit_h(7'd0), .digit_l(a_digit_l),
    .dot(1'b0), .tx(atx), .busy(a_busy), .sat(a_sat));

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // UART models: tx_done pulses about 20 cycles after each tx_start.
  int   m_cnt, a_cnt;
  logic m_done_r, a_done_r;
  assign mtx.tx_done = m_done_r | inj_done;
  assign atx.tx_done = a_done_r;

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_cnt <= 0; m_done_r <= 1'b0; a_cnt <= 0; a_done_r <= 1'b0;
    end else begin
      m_done_r <= 1'b0;
      a_done_r <= 1'b0;
      if (mtx.tx_start) m_cnt <= 20;
      else if (m_cnt != 0) begin m_cnt <= m_cnt - 1; if (m_cnt == 1) m_done_r <= 1'b1; end
      if (atx.tx_start) a_cnt <= 20;
      else if (a_cnt != 0) begin a_cnt <= a_cnt - 1; if (a_cnt == 1) a_done_r <= 1'b1; end
    end
  end

  logic [7:0] exp_q[$];
  logic [7:0] m_obs_q[$];
  logic [7:0] a_obs_q[$];
  int   m_starts = 0, a_starts = 0;
  int   m_done_cyc = 0, m_fall_cyc = 0, m_gap = 0;
  logic m_busy_prev = 1'b0;

  always @(negedge clk) begin
    if (mtx.tx_start) begin
      m_obs_q.push_back(mtx.tx_data);
      m_starts = m_starts + 1;
      m_gap = cyc - m_done_cyc;
    end
    if (mtx.tx_done) m_done_cyc = cyc;
    if (m_busy_prev && !busy) m_fall_cyc = cyc;
    m_busy_prev = busy;
    if (atx.tx_start) begin
      a_obs_q.push_back(atx.tx_data);
      a_starts = a_starts + 1;
    end
  end

  function automatic void push_frame(input int h, input int l, input bit d);
    int hc;
    int lc;
    hc = (h > 99) ? 99 : h;
    lc = (l > 99) ? 99 : l;
    exp_q.push_back(8'(48 + hc / 10));
    exp_q.push_back(8'(48 + hc % 10));
    exp_q.push_back(d ? 8'h2E : 8'h3A);
    exp_q.push_back(8'(48 + lc / 10));
    exp_q.push_back(8'(48 + lc % 10));
    exp_q.push_back(8'h0D);
    exp_q.push_back(8'h0A);
  endfunction

  task automatic pulse_req();
    @(posedge clk); #1 send_req = 1'b1;
    @(posedge clk); #1 send_req = 1'b0;
  endtask

  task automatic wait_idle(input bit use_auto, output bit ok);
    int quiet;
    quiet = 0;
    ok = 1'b0;
    for (int n = 0; n < 3000; n++) begin
      @(negedge clk);
      if ((use_auto ? a_busy : busy) == 1'b0) quiet++; else quiet = 0;
      if (quiet >= 4) begin ok = 1'b1; break; end
    end
  endtask

  task automatic wait_starts(input int target, output bit ok);
    ok = 1'b0;
    for (int n = 0; n < 3000; n++) begin
      @(negedge clk);
      if (m_starts >= target) begin ok = 1'b1; break; end
    end
  endtask

  task automatic test_reset();
    int s0;
    reset = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    checks++; if (mtx.tx_start !== 1'b0) begin failures++; $display("FAIL reset_tx_start: got %b expected 0", mtx.tx_start); end
    checks++; if (mtx.tx_data !== 8'h00) begin failures++; $display("FAIL reset_tx_data: got %02h expected 00", mtx.tx_data); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy: got %b expected 0", busy); end
    checks++; if (sat !== 1'b0) begin failures++; $display("FAIL reset_sat: got %b expected 0", sat); end
    reset = 1'b0;
    s0 = a_starts;
    repeat (10) @(negedge clk);
    checks++; if (a_starts != s0 || a_busy !== 1'b0) begin failures++; $display("FAIL reset_auto_quiet: got starts=%0d busy=%b expected 0/0", a_starts - s0, a_busy); end
  endtask

  task automatic test_basic();
    int s0, t0;
    bit ok, found;
    logic [7:0] e, o;
    s0 = m_starts;
    digit_h = 7'd12; digit_l = 7'd34; dot = 1'b0;
    push_frame(12, 34, 1'b0);
    @(posedge clk); #1 send_req = 1'b1; t0 = cyc;
    @(posedge clk); #1 send_req = 1'b0;
    found = 1'b0;
    for (int n = 0; n < 10; n++) begin
      @(negedge clk);
      if (mtx.tx_start) begin found = 1'b1; break; end
    end
    checks++; if (!found || (cyc - t0) != 2) begin failures++; $display("FAIL basic_latency: got %0d cycles expected 2", found ? cyc - t0 : -1); end
    repeat (5) @(negedge clk);
    checks++; if (mtx.tx_start !== 1'b0 || mtx.tx_data !== 8'h31) begin failures++; $display("FAIL basic_hold: got start=%b data=%02h expected 0/31", mtx.tx_start, mtx.tx_data); end
    wait_idle(1'b0, ok);
    checks++; if (!ok) begin failures++; $display("FAIL basic_timeout: got busy stuck expected idle"); end
    checks++; if (m_obs_q.size() != exp_q.size()) begin failures++; $display("FAIL basic_count: got %0d bytes expected %0d", m_obs_q.size(), exp_q.size()); end
    while (exp_q.size() != 0 && m_obs_q.size() != 0) begin
      e = exp_q.pop_front(); o = m_obs_q.pop_front();
      checks++; if (o !== e) begin failures++; $display("FAIL basic_byte: got %02h expected %02h", o, e); end
    end
    exp_q.delete(); m_obs_q.delete();
    checks++; if (m_starts - s0 != 7) begin failures++; $display("FAIL basic_starts: got %0d expected 7", m_starts - s0); end
    checks++; if (m_fall_cyc - m_done_cyc != 1) begin failures++; $display("FAIL basic_busy_fall: got %0d expected 1", m_fall_cyc - m_done_cyc); end
    checks++; if (m_gap != 1) begin failures++; $display("FAIL basic_done_to_start: got %0d expected 1", m_gap); end
    checks++; if (sat !== 1'b0) begin failures++; $display("FAIL basic_sat: got %b expected 0", sat); end
  endtask

  task automatic test_dot();
    bit ok;
    logic [7:0] e, o;
    digit_h = 7'd0; digit_l = 7'd5; dot = 1'b1;
    push_frame(0, 5, 1'b1);
    pulse_req();
    wait_idle(1'b0, ok);
    checks++; if (!ok || m_obs_q.size() != exp_q.size()) begin failures++; $display("FAIL dot_count: got %0d bytes expected %0d", m_obs_q.size(), exp_q.size()); end
    while (exp_q.size() != 0 && m_obs_q.size() != 0) begin
      e = exp_q.pop_front(); o = m_obs_q.pop_front();
      checks++; if (o !== e) begin failures++; $display("FAIL dot_byte: got %02h expected %02h", o, e); end
    end
    exp_q.delete(); m_obs_q.delete();
  endtask

  task automatic test_sat();
    bit ok;
    logic [7:0] e, o;
    digit_h = 7'd120; digit_l = 7'd99; dot = 1'b0;
    push_frame(120, 99, 1'b0);
    pulse_req();
    wait_idle(1'b0, ok);
    checks++; if (!ok || sat !== 1'b1) begin failures++; $display("FAIL sat_set: got %b expected 1", sat); end
    digit_h = 7'd10; digit_l = 7'd10;
    push_frame(10, 10, 1'b0);
    pulse_req();
    wait_idle(1'b0, ok);
    checks++; if (!ok || sat !== 1'b0) begin failures++; $display("FAIL sat_clear: got %b expected 0", sat); end
    checks++; if (m_obs_q.size() != exp_q.size()) begin failures++; $display("FAIL sat_count: got %0d bytes expected %0d", m_obs_q.size(), exp_q.size()); end
    while (exp_q.size() != 0 && m_obs_q.size() != 0) begin
      e = exp_q.pop_front(); o = m_obs_q.pop_front();
      checks++; if (o !== e) begin failures++; $display("FAIL sat_byte: got %02h expected %02h", o, e); end
    end
    exp_q.delete(); m_obs_q.delete();
  endtask

  task automatic test_coalesce();
    int s0;
    bit ok;
    logic [7:0] e, o;
    s0 = m_starts;
    digit_h = 7'd12; digit_l = 7'd34; dot = 1'b0;
    push_frame(12, 34, 1'b0);
    pulse_req();
    wait_starts(s0 + 3, ok);
    checks++; if (!ok) begin failures++; $display("FAIL coalesce_wait: got %0d starts expected 3", m_starts - s0); end
    for (int k = 0; k < 3; k++) begin
      pulse_req();
      repeat (3) @(posedge clk);
    end
    #1 digit_h = 7'd56; digit_l = 7'd78; dot = 1'b1;
    push_frame(56, 78, 1'b1);
    wait_idle(1'b0, ok);
    checks++; if (!ok || m_starts - s0 != 14) begin failures++; $display("FAIL coalesce_starts: got %0d expected 14", m_starts - s0); end
    while (exp_q.size() != 0 && m_obs_q.size() != 0) begin
      e = exp_q.pop_front(); o = m_obs_q.pop_front();
      checks++; if (o !== e) begin failures++; $display("FAIL coalesce_byte: got %02h expected %02h", o, e); end
    end
    exp_q.delete(); m_obs_q.delete();
  endtask

  task automatic test_back_to_back();
    int s0;
    bit ok, found;
    logic [7:0] e, o;
    s0 = m_starts;
    digit_h = 7'd21; digit_l = 7'd43; dot = 1'b0;
    push_frame(21, 43, 1'b0);
    push_frame(21, 43, 1'b0);
    pulse_req();
    wait_starts(s0 + 7, ok);
    found = 1'b0;
    for (int n = 0; n < 100 && ok; n++) begin
      if (mtx.tx_done) begin found = 1'b1; break; end
      @(negedge clk);
    end
    checks++; if (!found) begin failures++; $display("FAIL b2b_last_done: got none expected tx_done"); end
    send_req = 1'b1;
    @(posedge clk); #1 send_req = 1'b0;
    @(negedge clk);
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL b2b_idle_gap: got busy=%b expected 0", busy); end
    @(negedge clk);
    checks++; if (busy !== 1'b1) begin failures++; $display("FAIL b2b_restart: got busy=%b expected 1", busy); end
    wait_idle(1'b0, ok);
    checks++; if (!ok || m_starts - s0 != 14) begin failures++; $display("FAIL b2b_starts: got %0d expected 14", m_starts - s0); end
    while (exp_q.size() != 0 && m_obs_q.size() != 0) begin
      e = exp_q.pop_front(); o = m_obs_q.pop_front();
      checks++; if (o !== e) begin failures++; $display("FAIL b2b_byte: got %02h expected %02h", o, e); end
    end
    exp_q.delete(); m_obs_q.delete();
  endtask

  task automatic test_done_ignored();
    int s0;
    s0 = m_starts;
    @(posedge clk); #1 inj_done = 1'b1;
    @(posedge clk); #1 inj_done = 1'b0;
    repeat (10) @(negedge clk);
    checks++; if (m_starts != s0 || busy !== 1'b0) begin failures++; $display("FAIL idle_done_ignored: got starts=%0d busy=%b expected 0/0", m_starts - s0, busy); end
  endtask

  task automatic test_reset_mid();
    int s0;
    bit ok;
    logic [7:0] e, o;
    s0 = m_starts;
    digit_h = 7'd120; digit_l = 7'd34; dot = 1'b0;
    pulse_req();
    wait_starts(s0 + 4, ok);
    repeat (3) @(posedge clk);
    #1;
    checks++; if (!ok || busy !== 1'b1 || sat !== 1'b1) begin failures++; $display("FAIL rst_mid_pre: got busy=%b sat=%b expected 1/1", busy, sat); end
    reset = 1'b1;
    #1;
    checks++; if (mtx.tx_start !== 1'b0 || mtx.tx_data !== 8'h00 || busy !== 1'b0 || sat !== 1'b0) begin
      failures++; $display("FAIL rst_mid_outputs: got start=%b data=%02h busy=%b sat=%b expected 0/00/0/0", mtx.tx_start, mtx.tx_data, busy, sat);
    end
    m_obs_q.delete(); exp_q.delete();
    @(posedge clk); #1 reset = 1'b0;
    s0 = m_starts;
    repeat (50) @(negedge clk);
    checks++; if (m_starts != s0) begin failures++; $display("FAIL rst_mid_quiet: got %0d starts expected 0", m_starts - s0); end
    digit_h = 7'd12; digit_l = 7'd34;
    push_frame(12, 34, 1'b0);
    pulse_req();
    wait_idle(1'b0, ok);
    checks++; if (!ok || m_starts - s0 != 7) begin failures++; $display("FAIL rst_mid_starts: got %0d expected 7", m_starts - s0); end
    while (exp_q.size() != 0 && m_obs_q.size() != 0) begin
      e = exp_q.pop_front(); o = m_obs_q.pop_front();
      checks++; if (o !== e) begin failures++; $display("FAIL rst_mid_byte: got %02h expected %02h", o, e); end
    end
    exp_q.delete(); m_obs_q.delete();
  endtask

  task automatic test_auto();
    int s0;
    bit ok;
    logic [7:0] e, o;
    @(posedge clk); #1 reset = 1'b1; a_digit_l = 7'd0;
    @(posedge clk); #1 reset = 1'b0;
    a_obs_q.delete(); exp_q.delete();
    s0 = a_starts;
    @(posedge clk); #1 a_digit_l = 7'd1;
    push_frame(0, 1, 1'b0);
    wait_idle(1'b1, ok);
    repeat (20) @(posedge clk);
    #1 a_digit_l = 7'd2;
    push_frame(0, 2, 1'b0);
    wait_idle(1'b1, ok);
    checks++; if (!ok || a_starts - s0 != 14) begin failures++; $display("FAIL auto_wide_starts: got %0d expected 14", a_starts - s0); end
    while (exp_q.size() != 0 && a_obs_q.size() != 0) begin
      e = exp_q.pop_front(); o = a_obs_q.pop_front();
      checks++; if (o !== e) begin failures++; $display("FAIL auto_wide_byte: got %02h expected %02h", o, e); end
    end
    exp_q.delete(); a_obs_q.delete();
    s0 = a_starts;
    @(posedge clk); #1 a_digit_l = 7'd3;
    @(posedge clk); #1 a_digit_l = 7'd4;
    push_frame(0, 4, 1'b0);
    push_frame(0, 4, 1'b0);
    wait_idle(1'b1, ok);
    checks++; if (!ok || a_starts - s0 != 14) begin failures++; $display("FAIL auto_tight_starts: got %0d expected 14", a_starts - s0); end
    while (exp_q.size() != 0 && a_obs_q.size() != 0) begin
      e = exp_q.pop_front(); o = a_obs_q.pop_front();
      checks++; if (o !== e) begin failures++; $display("FAIL auto_tight_byte: got %02h expected %02h", o, e); end
    end
    exp_q.delete(); a_obs_q.delete();
    checks++; if (a_sat !== 1'b0) begin failures++; $display("FAIL auto_sat: got %b expected 0", a_sat); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_dot();
    test_sat();
    test_coalesce();
    test_back_to_back();
    test_done_ignored();
    test_reset_mid();
    test_auto();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: got simulation still running expected finished");
    $fatal(1, "watchdog expired");
  end

endmodule
